// File: rtl/mux_n_input_reg.sv
// N-channel W-bit operand mux into one registered output slot with valid/ready
// flow control; manual select by S or round-robin arbitration over REQ.
module mux_n_input_reg #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N*W-1:0]       IN,
  input  logic                 MODE,
  input  logic [$clog2(N)-1:0] S,
  input  logic                 IN_VALID,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         ACK,
  output logic [W-1:0]         OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [$clog2(N)-1:0] CH
);

  localparam int SW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_ch;
  logic          rr_hit;
  logic [SW-1:0] sel_ch;
  logic          want;
  logic          free;
  logic          capture;

  // Round-robin search starts just after the last granted channel. Scanning
  // from the far end downward lets the nearest requester overwrite the rest.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rr_ch  = ptr;
    rr_hit = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (REQ[(int'(ptr) + k) % N]) begin
        rr_ch  = SW'((int'(ptr) + k) % N);
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    free    = !OUT_VALID || OUT_READY;
    sel_ch  = MODE ? rr_ch : S;
    want    = MODE ? rr_hit : (IN_VALID && (int'(S) < N));
    capture = !RST && free && want;
    ACK     = capture ? (ONE_HOT0 << sel_ch) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      CH        <= '0;
      ptr       <= SW'(N - 1);
    end else if (capture) begin
      OUT       <= IN[int'(sel_ch)*W +: W];
      CH        <= sel_ch;
      OUT_VALID <= 1'b1;
      if (MODE) ptr <= sel_ch;
    end else if (OUT_READY) begin
      // Consumed with nothing new: data and channel index keep their last value.
      OUT_VALID <= 1'b0;
    end
  end

endmodule
